// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/memory/writeback
// phases and drives datapath enables and selects as Moore outputs.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_op;
    logic [1:0] res;
    logic       done;
    logic       illegal;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_b = 2'b10;
        ctrl.res   = 2'b10;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl.alu_a = 2'b01;
        ctrl.alu_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            ctrl.illegal = 1'b1;
            ctrl.done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_a = 2'b10;
        ctrl.alu_b = 2'b01;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.adr_src = 1'b1;
        state_d      = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ctrl.res       = 2'b01;
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_MEMWRITE: begin
        // mem_write stays high for the whole wait so memory sees a stable request
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.done      = mem_ready;
        state_d        = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ctrl.alu_a  = 2'b10;
        ctrl.alu_op = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_a  = 2'b10;
        ctrl.alu_b  = 2'b01;
        ctrl.alu_op = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_a    = 2'b10;
        ctrl.alu_op   = 2'b01;
        ctrl.pc_write = zero;
        ctrl.done     = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_a    = 2'b01;
        ctrl.alu_b    = 2'b10;
        ctrl.pc_write = 1'b1;
        state_d       = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates outputs combinationally so they drop the instant rst_n falls.
  assign ctrl_g     = rst_n ? ctrl : '0;
  assign state      = rst_n ? state_q : 4'd0;
  assign pc_write   = ctrl_g.pc_write;
  assign adr_src    = ctrl_g.adr_src;
  assign ir_write   = ctrl_g.ir_write;
  assign mem_write  = ctrl_g.mem_write;
  assign reg_write  = ctrl_g.reg_write;
  assign alu_src_a  = ctrl_g.alu_a;
  assign alu_src_b  = ctrl_g.alu_b;
  assign alu_op     = ctrl_g.alu_op;
  assign result_src = ctrl_g.res;
  assign instr_done = ctrl_g.done;
  assign illegal_op = ctrl_g.illegal;

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op, input, 7 bits: opcode from instruction register, stable from DECODE until the instruction completes.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory access completes in this cycle.
REQ-006 SHALL have outputs pc_write, adr_src, ir_write, mem_write, reg_write, 1 bit each: datapath enables and selects.
REQ-007 SHALL have outputs alu_src_a, alu_src_b, alu_op, result_src, imm_src, 2 bits each: datapath selects (a: 00 PC, 01 oldPC, 10 rs1; b: 00 rs2, 01 imm, 10 const 4).
REQ-008 SHALL have output instr_done, 1 bit: one-cycle pulse on the last cycle of each instruction.
REQ-009 SHALL have output illegal_op, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-010 SHALL have output state, 4 bits: current FSM state, for debug.

Function
REQ-011 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL return to FETCH with no outputs asserted.
REQ-012 SHALL keep every output not listed for a state at 0.
REQ-013 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
REQ-014 FETCH SHALL assert ir_write and pc_write only when mem_ready=1, advance to DECODE when mem_ready=1, and otherwise remain in FETCH.
REQ-015 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00.
REQ-016 DECODE next state SHALL be: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL.
REQ-017 Any other opcode in DECODE SHALL go to FETCH and pulse both illegal_op and instr_done.
REQ-018 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00, then go to MEMREAD for 0000011 and to MEMWRITE for 0100011.
REQ-019 MEMREAD SHALL drive adr_src=1, result_src=00, and hold until mem_ready=1, then go to MEMWB.
REQ-020 MEMWB SHALL drive result_src=01 and reg_write=1, pulse instr_done, then go to FETCH.
REQ-021 MEMWRITE SHALL drive adr_src=1 and mem_write=1 continuously while waiting; on mem_ready=1 it SHALL pulse instr_done and go to FETCH.
REQ-022 EXECR SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10, then go to ALUWB.
REQ-023 EXECI SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10, then go to ALUWB.
REQ-024 ALUWB SHALL drive result_src=00 and reg_write=1, pulse instr_done, then go to FETCH.
REQ-025 BEQ SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, with pc_write=zero (combinational), pulse instr_done, then go to FETCH.
REQ-026 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then go to ALUWB.
REQ-027 imm_src SHALL decode combinationally from op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, other -> 00.
REQ-028 Latency with mem_ready=1 SHALL be: R/I 4 cycles, lw 5, sw 4, beq 3, jal 4, illegal 2.
REQ-029 mem_ready SHALL be ignored in all states except FETCH, MEMREAD and MEMWRITE.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=FETCH and, while low, force every output except imm_src to 0.
REQ-031 Assertion of rst_n mid-instruction (including during a mem_ready wait) SHALL abort the instruction with no instr_done pulse.
REQ-032 After rst_n rises, the first rising clock edge SHALL evaluate FETCH normally.

Verification
REQ-033 Reset, then op=0110011 with mem_ready=1 -> states 0,1,6,8; reg_write=1 only in ALUWB; instr_done in cycle 4.
REQ-034 op=0000011 with mem_ready low for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4; reg_write with result_src=01 only in MEMWB.
REQ-035 op=1100011 with zero=1, then zero=0 -> pc_write=1 in BEQ for the first case and 0 for the second; 3 cycles each.
REQ-036 op=1101111 -> states 0,1,10,8; pc_write=1 in FETCH and JAL; imm_src=11.
REQ-037 op=1111111 -> DECODE pulses illegal_op=1 and instr_done=1, then FETCH; no reg_write or mem_write asserted.
REQ-038 op=0100011, rst_n pulsed low during the MEMWRITE wait -> mem_write drops immediately; state=0; no instr_done.
